nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that runs one 4-bit full-adder slice (same sum/carry equations as the team's ripple adder) over multiple cycles to add or subtract wide operands, one nibble per clock, least-significant nibble first.
- Sits between a requester and the shared nibble datapath. It registers the operands, holds the inter-nibble carry, assembles the result and reports status with a start/busy/done handshake.

---
 rtl/nibble_serial_adder_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds or subtracts two W-bit operands by running a
// single 4-bit ripple slice over NIBBLES cycles, least-significant nibble first.
// A start/busy/done handshake frames each operation; the result is held until
// the next accepted start.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [IDX_W+1:0]   w_base;
  logic [3:0]         w_na;
  logic [3:0]         w_nb;
  logic [3:0]         w_s;
  logic [4:0]         w_c;

  // A start is only honoured when no operation is in flight.
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_base   = {r_idx, 2'b00};
  assign w_na     = r_op_a[w_base +: 4];
  assign w_nb     = r_op_b[w_base +: 4];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for NIBBLES cycles, one DONE cycle.
  always_comb begin
    // NOTE: the default assignment first guarantees w_next is driven on every
    // path, so no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One 4-bit ripple slice on the current nibble; w_c[3] is the carry into bit 3.
  always_comb begin
    w_s    = '0;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < 4; i++) begin
      w_s[i]   = w_na[i] ^ w_nb[i] ^ w_c[i];
      w_c[i+1] = (w_na[i] & w_nb[i]) | (w_na[i] & w_c[i]) | (w_nb[i] & w_c[i]);
    end
  end

  // Operand capture on accepted start; nibble-by-nibble accumulation during RUN.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the operand and result registers are reset too, so an aborted
    // operation leaves no stale result visible on sum/cout/ovf.
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert B once and seed the carry with 1.
      r_op_a  <= a;
      r_op_b  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= w_s;
      r_carry            <= w_c[4];
      r_idx              <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[4];
        r_ovf  <= w_c[3] ^ w_c[4];
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Testbench for nibble_serial_adder_ctrl: a 4-nibble and a 2-nibble instance,
// expected results queued at start and compared when done pulses.
module tb_nibble_serial_adder_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start2 = 1'b0;
  logic [7:0]  a2 = '0;
  logic [7:0]  b2 = '0;
  logic        cin2 = 1'b0;
  logic        sub2 = 1'b0;
  logic        busy2, done2, cout2, ovf2;
  logic [7:0]  sum2;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int BUDGET = 50;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic built on the + operator, independent of the slice.
  function automatic res_t model(logic [15:0] ta, logic [15:0] tb_, logic tcin, logic tsub);
    res_t        r;
    logic [15:0] bb;
    logic [16:0] full;
    bb     = tsub ? ~tb_ : tb_;
    full   = {1'b0, ta} + {1'b0, bb} + 17'(tsub ? 1'b1 : tcin);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (ta[15] == bb[15]) && (full[15] != ta[15]);
    return r;
  endfunction

  task automatic compare_result(string name);
    res_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at done", name);
      return;
    end
    e = sb.pop_front();
    if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
  endtask

  // Launch one operation, scramble the inputs after capture, wait for done.
  task automatic run_op(string name, logic [15:0] ta, logic [15:0] tb_, logic tcin,
                        logic tsub, res_t exp);
    int lat, busy_cnt;
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = ~tcin; sub = ~tsub;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < BUDGET) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected 5", name, lat);
    end
    n_checks++;
    if (busy_cnt !== 4) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d, expected 4", name, busy_cnt);
    end
    if (done) compare_result(name);
    else void'(sb.pop_back());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy, done, sum, cout, ovf);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
  endtask

  task automatic test_carry_ripple();
    run_op("ripple_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
    run_op("ripple_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0});
  endtask

  task automatic test_overflow_sub();
    run_op("ovf_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1});
    run_op("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    run_op("sub_8000_1",    16'h8000, 16'h0001, 1'b1, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rc, rs;
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op($sformatf("random_%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back('{16'h1010, 1'b0, 1'b0});
    tick();
    start = 1'b0;
    tick();
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < BUDGET) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL start_in_run latency: got %0d, expected 5", lat);
    end
    if (done) compare_result("start_in_run");
    else void'(sb.pop_back());
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL start_in_run_no_queue: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; start = 1'b1;
    sb.push_back('{16'h3334, 1'b0, 1'b0});
    tick();
    a = 16'h0003; b = 16'h0005; sub = 1'b1;
    sb.push_back('{16'hFFFE, 1'b0, 1'b0});
    lat = 1;
    while (!done && lat < BUDGET) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL b2b_first latency: got %0d, expected 5", lat);
    end
    compare_result("b2b_first");
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < BUDGET) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d cycles between done pulses, expected 5", lat);
    end
    compare_result("b2b_second");
  endtask

  task automatic test_reset_mid_run();
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, ovf} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy, done, sum, cout, ovf);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    run_op("after_reset_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
  endtask

  task automatic test_n2();
    int   lat;
    res_t e;
    a2 = 8'hF0; b2 = 8'h10; cin2 = 1'b0; sub2 = 1'b0; start2 = 1'b1;
    sb.push_back('{16'h0000, 1'b1, 1'b0});
    tick();
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < BUDGET) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL n2_latency: got %0d cycles, expected 3", lat);
    end
    e = sb.pop_front();
    n_checks++;
    if ({8'h00, sum2, cout2, ovf2} !== {e.sum, e.cout, e.ovf}) begin
      n_fail++;
      $display("FAIL n2_f0_10: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
               sum2, cout2, ovf2, e.sum[7:0], e.cout, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ripple();
    test_overflow_sub();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_n2();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
